mon_exp_host_if: RTL and testbench

- Byte-stream host front-end that acts as the initiator of the mon_exp start/stop protocol.
- Collects operands M_bar, x_bar, e and n from an 8-bit valid/ready byte stream and drives start on the exponentiation core.
- Waits for the core's stop, latches ans, then serialises the result back out on an 8-bit valid/ready byte stream.
- Sits between the host link (UART/SPI byte layer) and mon_exp.

---
 rtl/mon_exp_pkg.sv | 28 ++
 rtl/mon_exp_host_if_if.sv | 33 +++
 rtl/mon_exp_host_if_byte_serializer.sv | 48 ++++
 rtl/mon_exp_host_if.sv | 140 ++++++++++++++
 tb/tb_mon_exp_host_if.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mon_exp_pkg.sv
// Shared definitions for the mon_exp host front-end.
// Holds the controller state encoding, default byte counts and helpers that
// derive the operand/result byte counts from an operand width.
package mon_exp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        UNLOAD
    } state_e;

    localparam int unsigned BIT_LEN_DFLT = 64;
    localparam int unsigned OPND_BYTES   = 4 * BIT_LEN_DFLT / 8;
    localparam int unsigned RES_BYTES    = (BIT_LEN_DFLT + 8) / 8;

    // Bytes needed to carry M_bar, x_bar, e and n.
    function automatic int unsigned opnd_bytes(input int unsigned bit_len);
        return 4 * bit_len / 8;
    endfunction

    // Bytes needed to carry the BIT_LEN+1 bit result (top byte holds the carry bit).
    function automatic int unsigned res_bytes(input int unsigned bit_len);
        return (bit_len + 8) / 8;
    endfunction

endpackage

// File: rtl/mon_exp_host_if_if.sv
// Bus bundle of the mon_exp host front-end.
// Carries the rx byte stream (host -> block), the tx byte stream
// (block -> host) and the start/stop/operand/result link to the core.
// master: the front-end block; slave: the host link plus core.
interface mon_exp_host_if_if #(
    parameter int unsigned BIT_LEN = 64
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [BIT_LEN-1:0] core_M_bar;
    logic [BIT_LEN-1:0] core_x_bar;
    logic [BIT_LEN-1:0] core_e;
    logic [BIT_LEN-1:0] core_n;
    logic               core_start;
    logic               core_stop;
    logic [BIT_LEN:0]   core_ans;

    modport master (
        input  rx_data, rx_valid, tx_ready, core_stop, core_ans,
        output rx_ready, tx_data, tx_valid,
        output core_M_bar, core_x_bar, core_e, core_n, core_start
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, core_stop, core_ans,
        input  rx_ready, tx_data, tx_valid,
        input  core_M_bar, core_x_bar, core_e, core_n, core_start
    );
endinterface

// File: rtl/mon_exp_host_if_byte_serializer.sv
// Parallel-load byte serializer with a valid/ready output stream.
// Ports: clk, rst_n; load_i/data_i load a word (MS byte sent first);
// tx_ready_i from the sink; tx_data_o/tx_valid_o to the sink;
// last_o flags that the byte on tx_data_o is the final one.
module mon_exp_host_if_byte_serializer #(
    parameter int unsigned NBYTES = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [8*NBYTES-1:0] data_i,
    input  logic                tx_ready_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    output logic                last_o
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned CW   = $clog2(NBYTES + 1);

    logic [W-1:0]  shreg_q;
    logic [CW-1:0] cnt_q;
    logic          valid_q;
    logic          last_q;

    // Shift register doubles as the result holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            shreg_q <= data_i;
            cnt_q   <= CW'(NBYTES);
            valid_q <= 1'b1;
            last_q  <= (NBYTES == 1);
        end else if (valid_q && tx_ready_i) begin
            shreg_q <= {shreg_q[W-9:0], 8'h00};
            cnt_q   <= cnt_q - CW'(1);
            valid_q <= (cnt_q != CW'(1));
            last_q  <= (cnt_q == CW'(2));
        end
    end

    assign tx_data_o  = shreg_q[W-1 -: 8];
    assign tx_valid_o = valid_q;
    assign last_o     = last_q;
endmodule

// File: rtl/mon_exp_host_if.sv
// Host front-end for the mon_exp exponentiation core.
// Collects M_bar, x_bar, e, n (MS byte first) from the rx byte stream,
// raises core_start, waits for a fresh rising edge of core_stop (or times
// out), then streams the BIT_LEN+1 bit result back out MS byte first.
// Ports: clk, rst_n (async, active low); bus (master side of the host/core
// bundle); busy_o high outside IDLE; err_o sticky timeout flag.
module mon_exp_host_if
    import mon_exp_pkg::*;
#(
    parameter int unsigned BIT_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mon_exp_host_if_if.master   bus,
    output logic                busy_o,
    output logic                err_o
);
    localparam int unsigned NB    = opnd_bytes(BIT_LEN);
    localparam int unsigned RB    = res_bytes(BIT_LEN);
    localparam int unsigned SH_W  = 4 * BIT_LEN;
    localparam int unsigned RES_W = 8 * RB;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    state_e           state_q;
    logic [SH_W-1:0]  opnd_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             stop_seen_low_q;
    logic             rx_ready_q;
    logic             core_start_q;
    logic             busy_q;
    logic             err_q;

    logic             rx_fire_c;
    logic             done_c;
    logic             ser_last;
    logic             tx_last_fire_c;

    assign rx_fire_c      = bus.rx_valid && rx_ready_q;
    // Completion needs a low sample in WAIT first, so a stale-high stop is ignored.
    assign done_c         = (state_q == WAIT) && bus.core_stop && stop_seen_low_q;
    assign tx_last_fire_c = (state_q == UNLOAD) && bus.tx_valid && bus.tx_ready && ser_last;

    // Controller FSM with operand deserialisation and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            opnd_q          <= '0;
            byte_cnt_q      <= '0;
            to_cnt_q        <= '0;
            stop_seen_low_q <= 1'b0;
            rx_ready_q      <= 1'b0;
            core_start_q    <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire_c) begin
                        err_q      <= 1'b0;
                        opnd_q     <= {opnd_q[SH_W-9:0], bus.rx_data};
                        byte_cnt_q <= CNT_W'(1);
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (rx_fire_c) begin
                        opnd_q     <= {opnd_q[SH_W-9:0], bus.rx_data};
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        // Start is raised with the move to ISSUE so it is high in that cycle.
                        if (byte_cnt_q == CNT_W'(NB - 1)) begin
                            rx_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    to_cnt_q        <= '0;
                    stop_seen_low_q <= 1'b0;
                    state_q         <= WAIT;
                end
                WAIT: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (!bus.core_stop) begin
                        stop_seen_low_q <= 1'b1;
                    end
                    if (done_c) begin
                        core_start_q <= 1'b0;
                        state_q      <= UNLOAD;
                    end else if (to_cnt_q + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
                        err_q        <= 1'b1;
                        core_start_q <= 1'b0;
                        busy_q       <= 1'b0;
                        rx_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                UNLOAD: begin
                    if (tx_last_fire_c) begin
                        busy_q     <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result serialiser; ans is zero-extended so its carry bit forms the top byte.
    mon_exp_host_if_byte_serializer #(
        .NBYTES (RB)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (done_c),
        .data_i     (RES_W'(bus.core_ans)),
        .tx_ready_i (bus.tx_ready),
        .tx_data_o  (bus.tx_data),
        .tx_valid_o (bus.tx_valid),
        .last_o     (ser_last)
    );

    // First operand shifted in ends up in the top slice.
    assign bus.core_M_bar = opnd_q[4*BIT_LEN-1 -: BIT_LEN];
    assign bus.core_x_bar = opnd_q[3*BIT_LEN-1 -: BIT_LEN];
    assign bus.core_e     = opnd_q[2*BIT_LEN-1 -: BIT_LEN];
    assign bus.core_n     = opnd_q[BIT_LEN-1:0];
    assign bus.core_start = core_start_q;
    assign bus.rx_ready   = rx_ready_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_mon_exp_host_if.sv
// Self-checking bench for mon_exp_host_if (BIT_LEN=64, TIMEOUT_CYCLES=20).
// Drives operand streams, acts as the core, and checks the result stream
// against a reference built from the operand/result values.
module tb_mon_exp_host_if;

    localparam int unsigned BL  = 64;
    localparam int unsigned NBY = 32;
    localparam int unsigned RBY = 9;
    localparam int unsigned TO  = 20;

    typedef struct {
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] e;
        logic [63:0] n;
        logic [64:0] ans;
        int          delay;
        int          bp;
        logic        gaps;
        logic [71:0] exp_stream;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;
    logic err;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];

    mon_exp_host_if_if #(.BIT_LEN(BL)) bus ();

    mon_exp_host_if #(
        .BIT_LEN        (BL),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] m, input logic [63:0] x, input logic [63:0] e,
                                input logic [63:0] n, input logic [64:0] ans, input int delay,
                                input int bp, input logic gaps, input logic [71:0] exp_stream);
        vec_t v;
        v.m = m; v.x = x; v.e = e; v.n = n; v.ans = ans;
        v.delay = delay; v.bp = bp; v.gaps = gaps; v.exp_stream = exp_stream;
        return v;
    endfunction

    // Reference: result stream is ans zero-extended to 9 bytes, MS byte first.
    function automatic logic [71:0] model_stream(input logic [64:0] a);
        return 72'(a);
    endfunction

    // Reference: byte idx of the operand stream (M_bar, x_bar, e, n; MS byte first).
    function automatic logic [7:0] op_byte(input vec_t v, input int idx);
        logic [63:0] w;
        case (idx / 8)
            0:       w = v.m;
            1:       w = v.x;
            2:       w = v.e;
            default: w = v.n;
        endcase
        return w[8*(7-(idx%8)) +: 8];
    endfunction

    task automatic send_bytes(input vec_t v, input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            int g;
            bus.rx_data  = op_byte(v, i);
            bus.rx_valid = 1'b1;
            g = 0;
            while (!bus.rx_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!bus.rx_ready) chk("rx_ready_wait", 128'(bus.rx_ready), 128'(1));
            if (i == NBY - 1) chk("start_before_last", 128'(bus.core_start), 128'(0));
            @(negedge clk);
            if (v.gaps && i < NBY - 1) begin
                bus.rx_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_opnds(input vec_t v, input string tag);
        chk({tag, "_M_bar"}, 128'(bus.core_M_bar), 128'(v.m));
        chk({tag, "_x_bar"}, 128'(bus.core_x_bar), 128'(v.x));
        chk({tag, "_e"},     128'(bus.core_e),     128'(v.e));
        chk({tag, "_n"},     128'(bus.core_n),     128'(v.n));
    endtask

    task automatic run_load(input vec_t v);
        send_bytes(v, 0, NBY);
        chk("start_latency", 128'(bus.core_start), 128'(1));
        chk("rx_ready_issue", 128'(bus.rx_ready), 128'(0));
        chk("busy_issue", 128'(busy), 128'(1));
        check_opnds(v, "load");
    endtask

    task automatic collect(input logic [71:0] exp_stream, input int bp);
        int       got;
        int       guard;
        logic     prev_stall;
        logic     tog;
        logic     rdy;
        logic [7:0] prev_d;
        got = 0; guard = 0; prev_stall = 1'b0; tog = 1'b0; prev_d = 8'h00;
        while (got < int'(RBY) && guard < 300) begin
            if (prev_stall) chk("tx_hold", 128'({bus.tx_valid, bus.tx_data}), 128'({1'b1, prev_d}));
            case (bp)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.tx_ready = rdy;
            if (bus.tx_valid && rdy) begin
                chk("tx_byte", 128'(bus.tx_data), 128'(exp_stream[8*(int'(RBY)-1-got) +: 8]));
                got++;
            end
            prev_stall = bus.tx_valid && !rdy;
            prev_d     = bus.tx_data;
            @(negedge clk);
            guard++;
        end
        if (got < int'(RBY)) chk("tx_count", 128'(got), 128'(RBY));
        bus.tx_ready = 1'b0;
        chk("tx_valid_after", 128'(bus.tx_valid), 128'(0));
        chk("busy_after", 128'(busy), 128'(0));
        chk("start_after", 128'(bus.core_start), 128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        chk("idle_busy", 128'(busy), 128'(0));
        run_load(v);
        bus.core_stop = 1'b0;
        // Stray byte offered while the block is busy must be ignored.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        for (int k = 1; k <= v.delay; k++) begin
            @(negedge clk);
            if (k == 1) chk("rx_ready_wait_state", 128'(bus.rx_ready), 128'(0));
        end
        chk("start_held", 128'(bus.core_start), 128'(1));
        chk("tx_valid_wait", 128'(bus.tx_valid), 128'(0));
        bus.core_stop = 1'b1;
        bus.core_ans  = v.ans;
        @(negedge clk);
        chk("start_drop", 128'(bus.core_start), 128'(0));
        chk("tx_valid_rise", 128'(bus.tx_valid), 128'(1));
        bus.rx_valid  = 1'b0;
        bus.core_stop = 1'b0;
        bus.core_ans  = {1'($urandom), $urandom(), $urandom()};
        check_opnds(v, "held");
        collect(v.exp_stream, v.bp);
    endtask

    initial begin
        vec_t v;
        logic seen;
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
        bus.core_stop = 1'b0; bus.core_ans = '0;

        vecs.push_back(mk(64'd26, 64'd157, 64'd5, 64'd589, 65'h1_0000_0000_0000_0137, 10, 0, 1'b0,
                          72'h01_00_00_00_00_00_00_01_37));
        vecs.push_back(mk(64'd26, 64'd157, 64'd5, 64'd589, 65'h1_0000_0000_0000_0137, 10, 1, 1'b0,
                          72'h01_00_00_00_00_00_00_01_37));
        vecs.push_back(mk('1, '1, '1, '1, 65'h0_FFFF_FFFF_FFFF_FFFF, 2, 0, 1'b0,
                          72'h00_FF_FF_FF_FF_FF_FF_FF_FF));
        vecs.push_back(mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001,
                          64'h0F0F_0F0F_F0F0_F0F0, 65'h1_8000_0000_0000_0001, 18, 2, 1'b1,
                          72'h01_80_00_00_00_00_00_00_01));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 128'(bus.rx_ready), 128'(0));
        chk("rst_tx_valid", 128'(bus.tx_valid), 128'(0));
        chk("rst_tx_data", 128'(bus.tx_data), 128'(0));
        chk("rst_start", 128'(bus.core_start), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_opnds", 128'({bus.core_M_bar, bus.core_n}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", 128'(bus.rx_ready), 128'(1));

        // Directed table
        foreach (vecs[i]) run_vec(vecs[i]);

        // Stale stop: high through ISSUE and first WAIT cycle, low 3 cycles, then high
        v = mk(64'h11, 64'h22, 64'h33, 64'h44, 65'h0_DEAD_BEEF_CAFE_F00D, 0, 0, 1'b0, '0);
        bus.core_stop = 1'b1;
        bus.core_ans  = 65'h1_1111_1111_1111_1111;
        run_load(v);
        @(negedge clk);
        @(negedge clk);
        chk("stale_no_done", 128'({bus.core_start, bus.tx_valid}), 128'(2'b10));
        bus.core_stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stale_low_wait", 128'({bus.core_start, bus.tx_valid}), 128'(2'b10));
        @(negedge clk);
        bus.core_stop = 1'b1;
        bus.core_ans  = v.ans;
        @(negedge clk);
        chk("stale_done", 128'({bus.core_start, bus.tx_valid}), 128'(2'b01));
        bus.core_stop = 1'b0;
        bus.core_ans  = '0;
        collect(model_stream(v.ans), 0);

        // Timeout: stop never rises
        v = vecs[0];
        run_load(v);
        bus.core_stop = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            seen = seen | bus.tx_valid;
        end
        chk("to_still_busy", 128'({busy, err}), 128'(2'b10));
        @(negedge clk);
        seen = seen | bus.tx_valid;
        chk("to_idle", 128'(busy), 128'(0));
        chk("to_err", 128'(err), 128'(1));
        chk("to_start", 128'(bus.core_start), 128'(0));
        chk("to_no_tx", 128'(seen), 128'(0));
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 128'(err), 128'(1));
        send_bytes(vecs[3], 0, 1);
        chk("err_clear", 128'(err), 128'(0));
        chk("busy_load", 128'(busy), 128'(1));
        send_bytes(vecs[3], 1, 11);

        // Reset after 12 bytes loaded
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rx_ready", 128'(bus.rx_ready), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_opnds", 128'({bus.core_M_bar, bus.core_x_bar}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[3]);

        // Reset during WAIT drops start at once
        run_load(vecs[2]);
        repeat (3) @(negedge clk);
        chk("wait_start_pre", 128'(bus.core_start), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("wait_rst_start", 128'(bus.core_start), 128'(0));
        chk("wait_rst_busy", 128'(busy), 128'(0));
        chk("wait_rst_n", 128'(bus.core_n), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized transactions against the reference
        for (int r = 0; r < 8; r++) begin
            v.m   = {$urandom(), $urandom()};
            v.x   = {$urandom(), $urandom()};
            v.e   = {$urandom(), $urandom()};
            v.n   = {$urandom(), $urandom()};
            v.ans = {1'($urandom()), $urandom(), $urandom()};
            v.delay = $urandom_range(2, 18);
            v.bp    = $urandom_range(0, 2);
            v.gaps  = 1'b1;
            v.exp_stream = model_stream(v.ans);
            run_vec(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
